// File: rtl/crc_feed_master_pkg.sv
// Shared definitions for the CRC feed master: FSM states, slave register map, control words.
// The optional poll timeout is enabled with `CRC_FEED_TIMEOUT_EN.
package crc_feed_master_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StArm,
    StFeed,
    StPoll,
    StPwait,
    StRes,
    StRwait,
    StDisarm,
    StOut
  } state_e;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;

  localparam int unsigned CTRL_ARM    = 1;
  localparam int unsigned CTRL_DISARM = 0;

endpackage

// File: rtl/crc_feed_master_if.sv
// Register-style bus between the feed master and the CRC slave.
// Read data is registered by the slave and valid one cycle after m_read.
interface crc_feed_master_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  m_cs;
  logic                  m_write;
  logic                  m_read;
  logic [1:0]            m_addr;
  logic [DATA_WIDTH-1:0] m_write_data;
  logic [DATA_WIDTH-1:0] m_read_data;

  modport master (
    output m_cs,
    output m_write,
    output m_read,
    output m_addr,
    output m_write_data,
    input  m_read_data
  );

  modport slave (
    input  m_cs,
    input  m_write,
    input  m_read,
    input  m_addr,
    input  m_write_data,
    output m_read_data
  );

endinterface

// File: rtl/crc_feed_master_fifo.sv
// Synchronous FIFO holding {last, data} stream entries for the feed master.
// Push is dropped when full and pop is dropped when empty, regardless of the other side.
module crc_feed_master_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [PtrW:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH:0] mem_q [DEPTH];
  logic                do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + (PtrW + 1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= {last_i, data_i};
    end
  end

  assign {last_o, data_o} = mem_q[rd_ptr_q[PtrW-1:0]];

endmodule

// File: rtl/crc_feed_master.sv
// Sequencer that feeds buffered packets into the CRC slave and returns the result.
// Define CRC_FEED_TIMEOUT_EN to bound status polling to POLL_MAX failed attempts.
module crc_feed_master
  import crc_feed_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CRC_WIDTH  = 3,
  parameter int unsigned POLL_MAX   = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  crc_feed_master_if.master     m_bus,
  output logic                  crc_valid,
  output logic [CRC_WIDTH-1:0]  crc_result,
  input  logic                  crc_ack,
  output logic                  crc_error,
  output logic                  busy
);

  logic                  fifo_full, fifo_empty, fifo_pop, fifo_head_last;
  logic [DATA_WIDTH-1:0] fifo_head_data;

  state_e                state_q, state_d;
  logic                  cs_q, cs_d;
  logic                  write_q, write_d;
  logic                  read_q, read_d;
  logic [1:0]            addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  last_q, last_d;
  logic                  crc_valid_q, crc_valid_d;
  logic [CRC_WIDTH-1:0]  crc_result_q, crc_result_d;

`ifdef CRC_FEED_TIMEOUT_EN
  localparam logic [7:0] PollLimit = 8'(POLL_MAX - 1);
  logic [7:0] poll_cnt_q, poll_cnt_d;
  logic       crc_error_q, crc_error_d;
`else
  logic [7:0] unused_poll_max;
  assign unused_poll_max = 8'(POLL_MAX);
`endif

  logic unused_read_data;
  assign unused_read_data = ^m_bus.m_read_data;

  assign s_ready = !fifo_full;

  crc_feed_master_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (s_valid),
    .data_i  (s_data),
    .last_i  (s_last),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head_data),
    .last_o  (fifo_head_last),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Bus strobes are computed on the transition into a state so that they are
  // visible, registered, for exactly the cycle spent in that state.
  always_comb begin
    state_d      = state_q;
    cs_d         = 1'b0;
    write_d      = 1'b0;
    read_d       = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_d       = last_q;
    crc_valid_d  = crc_valid_q;
    crc_result_d = crc_result_q;
    fifo_pop     = 1'b0;
`ifdef CRC_FEED_TIMEOUT_EN
    poll_cnt_d   = poll_cnt_q;
    crc_error_d  = crc_error_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StArm;
          cs_d    = 1'b1;
          write_d = 1'b1;
          addr_d  = ADDR_CTRL;
          wdata_d = DATA_WIDTH'(CTRL_ARM);
          last_d  = 1'b0;
`ifdef CRC_FEED_TIMEOUT_EN
          poll_cnt_d  = '0;
          crc_error_d = 1'b0;
`endif
        end
      end

      StArm, StFeed: begin
        state_d = StFeed;
        if ((state_q == StFeed) && write_q && last_q) begin
          // The last word is on the bus this cycle; start polling next.
          state_d = StPoll;
          cs_d    = 1'b1;
          read_d  = 1'b1;
          addr_d  = ADDR_STAT;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cs_d     = 1'b1;
          write_d  = 1'b1;
          addr_d   = ADDR_DATA;
          wdata_d  = fifo_head_data;
          last_d   = fifo_head_last;
        end
      end

      StPoll: begin
        state_d = StPwait;
      end

      StPwait: begin
        if (m_bus.m_read_data[0]) begin
          state_d = StRes;
          cs_d    = 1'b1;
          read_d  = 1'b1;
          addr_d  = ADDR_CTRL;
        end else begin
`ifdef CRC_FEED_TIMEOUT_EN
          if (poll_cnt_q == PollLimit) begin
            state_d      = StDisarm;
            cs_d         = 1'b1;
            write_d      = 1'b1;
            addr_d       = ADDR_CTRL;
            wdata_d      = DATA_WIDTH'(CTRL_DISARM);
            crc_result_d = '0;
            crc_error_d  = 1'b1;
          end else begin
            poll_cnt_d = poll_cnt_q + 8'd1;
            state_d    = StPoll;
            cs_d       = 1'b1;
            read_d     = 1'b1;
            addr_d     = ADDR_STAT;
          end
`else
          state_d = StPoll;
          cs_d    = 1'b1;
          read_d  = 1'b1;
          addr_d  = ADDR_STAT;
`endif
        end
      end

      StRes: begin
        state_d = StRwait;
      end

      StRwait: begin
        crc_result_d = m_bus.m_read_data[CRC_WIDTH-1:0];
        state_d      = StDisarm;
        cs_d         = 1'b1;
        write_d      = 1'b1;
        addr_d       = ADDR_CTRL;
        wdata_d      = DATA_WIDTH'(CTRL_DISARM);
      end

      StDisarm: begin
        state_d     = StOut;
        crc_valid_d = 1'b1;
      end

      StOut: begin
        if (crc_ack) begin
          state_d     = StIdle;
          crc_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cs_q         <= 1'b0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_q       <= 1'b0;
      crc_valid_q  <= 1'b0;
      crc_result_q <= '0;
`ifdef CRC_FEED_TIMEOUT_EN
      poll_cnt_q   <= '0;
      crc_error_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cs_q         <= cs_d;
      write_q      <= write_d;
      read_q       <= read_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_q       <= last_d;
      crc_valid_q  <= crc_valid_d;
      crc_result_q <= crc_result_d;
`ifdef CRC_FEED_TIMEOUT_EN
      poll_cnt_q   <= poll_cnt_d;
      crc_error_q  <= crc_error_d;
`endif
    end
  end

  assign m_bus.m_cs         = cs_q;
  assign m_bus.m_write      = write_q;
  assign m_bus.m_read       = read_q;
  assign m_bus.m_addr       = addr_q;
  assign m_bus.m_write_data = wdata_q;

  assign crc_valid  = crc_valid_q;
  assign crc_result = crc_result_q;
  assign busy       = (state_q != StIdle);

`ifdef CRC_FEED_TIMEOUT_EN
  assign crc_error = crc_error_q;
`else
  assign crc_error = 1'b0;
`endif

endmodule
